pc_load_unit: RTL and testbench
===============================

PC_LOAD_UNIT -- requirements
Module: pc_load_unit

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 1, meaning the cycles from a mem_rd cycle to the cycle in which mem_out holds valid data (legal range 1..4).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port pc_load  input  1  level request to restore the PC from memory; held high for the whole operation.
REQ-005 The block SHALL have port mem_out  input  BYTE (8)  memory read data.
REQ-006 The block SHALL have port mem_rd  output  1  one-cycle read strobe to memory.
REQ-007 The block SHALL have port mem_sel  output  1  address select qualifying mem_rd: 1 = upper-byte slot, 0 = lower-byte slot.
REQ-008 The block SHALL have port pc_out  output  PROGRAM_COUNTER (16)  reassembled program counter.
REQ-009 The block SHALL have port pc_valid  output  1  one-cycle pulse marking a new pc_out.
REQ-010 The block SHALL have port busy  output  1  high in every state except IDLE and HOLD.

Function
REQ-011 The block SHALL be the reader counterpart of the PC store path, which writes the lower byte first and the upper byte second: it reads the upper byte first and the lower byte second (stack-pop order).
REQ-012 The block SHALL implement the states IDLE, RD_UPPER, WAIT_UPPER, RD_LOWER, WAIT_LOWER, DONE and HOLD.
REQ-013 From IDLE with pc_load sampled high, the next state SHALL be RD_UPPER; with pc_load low, the state SHALL remain IDLE.
REQ-014 In RD_UPPER, mem_rd=1 and mem_sel=1 for exactly one cycle; the next state SHALL be WAIT_UPPER with the latency counter loaded to READ_LATENCY-1.
REQ-015 WAIT_UPPER SHALL last exactly READ_LATENCY cycles; on its final cycle the block SHALL capture mem_out into an internal upper-byte hold register, and the next state SHALL be RD_LOWER.
REQ-016 In RD_LOWER, mem_rd=1 and mem_sel=0 for one cycle; WAIT_LOWER SHALL then last READ_LATENCY cycles.
REQ-017 On the final WAIT_LOWER cycle, the block SHALL load pc_out[15:8] from the hold register and pc_out[7:0] from mem_out at the same edge; the next state SHALL be DONE.
REQ-018 pc_out SHALL never show a partially updated value, and SHALL hold its value at all times other than the REQ-017 update.
REQ-019 In DONE, pc_valid SHALL be 1 for exactly one cycle; the next state SHALL be HOLD if pc_load is high, else IDLE.
REQ-020 In HOLD, no read SHALL be issued; the state SHALL remain HOLD while pc_load is high and go to IDLE when pc_load is low, so a held request causes exactly one load.
REQ-021 If pc_load is low in any of RD_UPPER, WAIT_UPPER, RD_LOWER or WAIT_LOWER, the next state SHALL be IDLE (abort): no further mem_rd, pc_out unchanged, no pc_valid.
REQ-022 An abort on the final WAIT_LOWER cycle SHALL take priority over the pc_out update.
REQ-023 mem_rd SHALL be 0 outside RD_UPPER and RD_LOWER.
REQ-024 mem_sel SHALL be 0 whenever mem_rd is 0.
REQ-025 Latency SHALL be fixed: with pc_load sampled high at edge E0, pc_valid is high in cycle 2*READ_LATENCY+3 after E0 (cycle 5 for READ_LATENCY=1).
REQ-026 The latency counter SHALL be 2 bits wide and SHALL count down without wrapping below 0.

Reset
REQ-027 While rst_n is low, the block SHALL immediately, independent of clk, force state=IDLE, pc_out=16'h0000, pc_valid=0, mem_rd=0, mem_sel=0, busy=0, hold register=8'h00 and counter=0.
REQ-028 Reset asserted mid-operation SHALL discard the partial load; after rst_n rises, the block SHALL issue no mem_rd until pc_load is sampled high in IDLE.
REQ-029 If pc_load is already high when rst_n deasserts, the block SHALL start a load on the first rising clk edge with rst_n high.

Verification
REQ-030 Basic load, READ_LATENCY=1: memory returns 8'h12 for mem_sel=1 and 8'h34 for mem_sel=0; pulse pc_load for 5 cycles -> mem_rd in cycles 1 and 3 with mem_sel 1 then 0; pc_out=16'h1234 and pc_valid=1 in cycle 5 only.
REQ-031 READ_LATENCY=3, data 8'hAB/8'hCD -> mem_rd cycles 1 and 5; pc_valid in cycle 9; pc_out=16'hABCD; pc_out unchanged from its old value through cycle 8.
REQ-032 Held request: pc_load high for 20 cycles -> exactly one pc_valid pulse and two mem_rd pulses; busy=0 in HOLD; dropping then re-raising pc_load -> one new load.
REQ-033 Abort: pc_load drops during WAIT_LOWER -> state IDLE next cycle, no pc_valid, pc_out keeps its prior value (16'h1234).
REQ-034 Reset mid-load: rst_n low asynchronously during WAIT_UPPER -> all outputs zero before the next clk edge; after release with pc_load low, no mem_rd for 10 cycles.
REQ-035 Back-to-back: pc_load low for 1 cycle after DONE, then high -> second load returns 16'h5678 with identical cycle timing.

Source files
------------

// File: rtl/pc_load_unit.sv
// rtl/pc_load_unit.sv - restores a 16-bit program counter from memory, upper byte first
// Two reads (upper then lower) separated by a fixed read latency; pc_out changes only once both bytes are in.
module pc_load_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_load,
  input  logic [7:0]  mem_out,
  output logic        mem_rd,
  output logic        mem_sel,
  output logic [15:0] pc_out,
  output logic        pc_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_UPPER,
    WAIT_UPPER,
    RD_LOWER,
    WAIT_LOWER,
    DONE,
    HOLD
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_next;
  logic [7:0]  r_upper;
  logic [15:0] r_pc;
  logic        w_cap_upper;
  logic        w_cap_pc;
  logic        w_wait_done;

  assign w_wait_done = (r_cnt == 2'd0);

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_cap_upper = 1'b0;
    w_cap_pc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (pc_load) w_next = RD_UPPER;
      end
      RD_UPPER: begin
        if (!pc_load) begin
          w_next = IDLE;
        end else begin
          w_next     = WAIT_UPPER;
          w_cnt_next = LAT_INIT;
        end
      end
      WAIT_UPPER: begin
        if (!pc_load) begin
          w_next     = IDLE;
          w_cnt_next = 2'd0;
        end else if (w_wait_done) begin
          w_next      = RD_LOWER;
          w_cap_upper = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      RD_LOWER: begin
        if (!pc_load) begin
          w_next = IDLE;
        end else begin
          w_next     = WAIT_LOWER;
          w_cnt_next = LAT_INIT;
        end
      end
      WAIT_LOWER: begin
        // a dropped request wins over the final capture, so pc_out stays intact
        if (!pc_load) begin
          w_next     = IDLE;
          w_cnt_next = 2'd0;
        end else if (w_wait_done) begin
          w_next   = DONE;
          w_cap_pc = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      DONE: begin
        w_next = pc_load ? HOLD : IDLE;
      end
      HOLD: begin
        if (!pc_load) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_upper <= 8'h00;
      r_pc    <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_cap_upper) r_upper <= mem_out;
      if (w_cap_pc)    r_pc    <= {r_upper, mem_out};
    end
  end

  assign mem_rd   = (r_state == RD_UPPER) || (r_state == RD_LOWER);
  assign mem_sel  = (r_state == RD_UPPER);
  assign pc_valid = (r_state == DONE);
  assign busy     = (r_state != IDLE) && (r_state != HOLD);
  assign pc_out   = r_pc;

endmodule

// File: tb/tb_pc_load_unit.sv
// tb/tb_pc_load_unit.sv - randomized and directed bench for pc_load_unit at latencies 1 and 3
// The model tracks each load as a cycle index k since the request was accepted.
module tb_pc_load_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_load;
  logic [7:0]  mo [2];
  logic [1:0]  rd_w;
  logic [1:0]  sel_w;
  logic [1:0]  pv_w;
  logic [1:0]  busy_w;
  logic [15:0] pc_w [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          k      [2];
  bit          held   [2];
  logic [15:0] exp_pc [2];
  logic [7:0]  up     [2];
  logic [7:0]  lo     [2];
  bit          pend_v [2][8];
  logic [7:0]  pend_d [2][8];
  int          rd_cnt [2];
  int          pv_cnt [2];

  pc_load_unit #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .mem_out(mo[0]),
    .mem_rd(rd_w[0]), .mem_sel(sel_w[0]), .pc_out(pc_w[0]),
    .pc_valid(pv_w[0]), .busy(busy_w[0])
  );

  pc_load_unit #(.READ_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .mem_out(mo[1]),
    .mem_rd(rd_w[1]), .mem_sel(sel_w[1]), .pc_out(pc_w[1]),
    .pc_valid(pv_w[1]), .busy(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      k[d]      = 0;
      held[d]   = 1'b0;
      exp_pc[d] = 16'h0000;
    end
  endtask

  // Advance the model by one clock edge that sampled 'load'.
  task automatic model_edge(input int d, input logic load);
    int last;
    last = 2 * lat(d) + 3;
    if (k[d] == 0) begin
      if (held[d]) held[d] = load;
      else if (load) k[d] = 1;
    end else if (k[d] == last) begin
      k[d]    = 0;
      held[d] = load;
    end else if (!load) begin
      k[d] = 0;
    end else begin
      if (k[d] == last - 1) exp_pc[d] = {up[d], lo[d]};
      k[d]++;
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      logic e_rd, e_sel, e_pv, e_busy;
      e_rd   = (k[d] == 1) || (k[d] == lat(d) + 2);
      e_sel  = (k[d] == 1);
      e_pv   = (k[d] == 2 * lat(d) + 3);
      e_busy = (k[d] != 0);
      check("mem_rd",   d, 16'(rd_w[d]),   16'(e_rd));
      check("mem_sel",  d, 16'(sel_w[d]),  16'(e_sel));
      check("pc_valid", d, 16'(pv_w[d]),   16'(e_pv));
      check("busy",     d, 16'(busy_w[d]), 16'(e_busy));
      check("pc_out",   d, pc_w[d],        exp_pc[d]);
    end
  endtask

  task automatic drive_mem();
    for (int d = 0; d < 2; d++) begin
      int slot;
      if (rd_w[d]) begin
        slot = (cyc + lat(d)) % 8;
        pend_v[d][slot] = 1'b1;
        pend_d[d][slot] = sel_w[d] ? up[d] : lo[d];
      end
      slot = cyc % 8;
      mo[d] = pend_v[d][slot] ? pend_d[d][slot] : 8'($urandom);
      pend_v[d][slot] = 1'b0;
    end
  endtask

  task automatic step(input logic load);
    pc_load = load;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset();
      else model_edge(d, load);
    end
    compare_all();
    for (int d = 0; d < 2; d++) begin
      rd_cnt[d] += int'(rd_w[d]);
      pv_cnt[d] += int'(pv_w[d]);
    end
    drive_mem();
  endtask

  task automatic do_async_reset(input logic load);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check("rst_pc_out", d, pc_w[d], 16'h0000);
      check("rst_rd",     d, 16'(rd_w[d]),   16'h0);
      check("rst_busy",   d, 16'(busy_w[d]), 16'h0);
    end
    compare_all();
    step(load);
    #2 rst_n = 1'b1;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      rd_cnt[d] = 0;
      pv_cnt[d] = 0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    pc_load = 1'b0;
    mo[0]   = 8'h00;
    mo[1]   = 8'h00;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 8; s++) pend_v[d][s] = 1'b0;
    model_reset();
    clear_counts();
    #2;
    for (int d = 0; d < 2; d++) begin
      check("init_pc_out", d, pc_w[d], 16'h0000);
      check("init_valid",  d, 16'(pv_w[d]),  16'h0);
      check("init_sel",    d, 16'(sel_w[d]), 16'h0);
    end
    #10 rst_n = 1'b1;
    step(1'b0);
    step(1'b0);

    // Basic load: 12/34 at latency 1, AB/CD at latency 3
    up[0] = 8'h12; lo[0] = 8'h34;
    up[1] = 8'hAB; lo[1] = 8'hCD;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1);
      if (i == 1 || i == 3) check("basic_rd0", 0, 16'(rd_w[0]), 16'h1);
      if (i == 1 || i == 5) check("basic_rd1", 1, 16'(rd_w[1]), 16'h1);
      if (i == 5) begin
        check("basic_pc0", 0, pc_w[0], 16'h1234);
        check("basic_pv0", 0, 16'(pv_w[0]), 16'h1);
      end
      if (i == 8) check("basic_old_pc1", 1, pc_w[1], 16'h0000);
      if (i == 9) begin
        check("basic_pc1", 1, pc_w[1], 16'hABCD);
        check("basic_pv1", 1, 16'(pv_w[1]), 16'h1);
      end
    end
    step(1'b0);
    step(1'b0);

    // Held request: exactly one load, then one more after a re-raise
    clear_counts();
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int d = 0; d < 2; d++) begin
      check("held_pv_cnt", d, 16'(pv_cnt[d]), 16'd1);
      check("held_rd_cnt", d, 16'(rd_cnt[d]), 16'd2);
      check("hold_busy",   d, 16'(busy_w[d]), 16'h0);
    end
    step(1'b0);
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b1);
    for (int d = 0; d < 2; d++) check("reraise_pv_cnt", d, 16'(pv_cnt[d]), 16'd1);
    step(1'b0);
    step(1'b0);

    // Abort in WAIT_LOWER of the latency-1 unit
    up[0] = 8'h9A; lo[0] = 8'hBC;
    clear_counts();
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b0);
    check("abort_busy", 0, 16'(busy_w[0]), 16'h0);
    step(1'b0);
    step(1'b0);
    check("abort_pc0",     0, pc_w[0], 16'h1234);
    check("abort_pc1",     1, pc_w[1], 16'hABCD);
    check("abort_pv_cnt0", 0, 16'(pv_cnt[0]), 16'd0);

    // Back-to-back loads with a one-cycle gap
    up[0] = 8'h56; lo[0] = 8'h78;
    up[1] = 8'h56; lo[1] = 8'h78;
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 1; i <= 5; i++) begin
        step(1'b1);
        if (i == 3) check("b2b_rd0", 0, 16'(rd_w[0]), 16'h1);
        if (i == 5) begin
          check("b2b_pc0", 0, pc_w[0], 16'h5678);
          check("b2b_pv0", 0, 16'(pv_w[0]), 16'h1);
        end
      end
      step(1'b0);
    end
    step(1'b0);

    // Reset during WAIT_UPPER, then a quiet interval with pc_load low
    step(1'b1);
    step(1'b1);
    do_async_reset(1'b0);
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b0);
    for (int d = 0; d < 2; d++) check("post_rst_rd_cnt", d, 16'(rd_cnt[d]), 16'd0);

    // pc_load already high when reset releases
    do_async_reset(1'b1);
    step(1'b1);
    for (int d = 0; d < 2; d++) begin
      check("rst_release_rd",  d, 16'(rd_w[d]),  16'h1);
      check("rst_release_sel", d, 16'(sel_w[d]), 16'h1);
    end
    for (int i = 0; i < 12; i++) step(1'b1);
    step(1'b0);

    // Random traffic with occasional resets
    begin
      logic load;
      load = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        for (int d = 0; d < 2; d++)
          if (k[d] == 0) begin
            up[d] = 8'($urandom);
            lo[d] = 8'($urandom);
          end
        if ($urandom_range(0, 5) == 0) load = ~load;
        if ($urandom_range(0, 299) == 0) do_async_reset(load);
        else step(load);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
